// File: rtl/fetch_sequencer_if.sv
// Bus between the fetch sequencer and its PC/ROM and decode/execute neighbours.
// The master modport is the sequencer; the slave modport is the datapath side.
interface fetch_sequencer_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
);
    logic              run;
    logic [DATA_W-1:0] rom_data;
    logic              exec_done;
    logic              branch_req;
    logic [ADDR_W-1:0] branch_target;
    logic              halt;
    logic              rom_rd;
    logic              pc_inc;
    logic              pc_load;
    logic [ADDR_W-1:0] pc_load_addr;
    logic [DATA_W-1:0] ir;
    logic              ir_valid;
    logic              halted;
    logic              busy;
    logic [CNT_W-1:0]  retired;

    modport master (
        input  run, rom_data, exec_done, branch_req, branch_target, halt,
        output rom_rd, pc_inc, pc_load, pc_load_addr, ir, ir_valid, halted, busy, retired
    );

    modport slave (
        output run, rom_data, exec_done, branch_req, branch_target, halt,
        input  rom_rd, pc_inc, pc_load, pc_load_addr, ir, ir_valid, halted, busy, retired
    );
endinterface

// File: rtl/fetch_sequencer.sv
// Fetch / decode / execute sequencer: owns PC advancement, strobes the ROM,
// latches the instruction register and counts retired instructions.
module fetch_sequencer #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 32,
    parameter int ROM_LAT = 1,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               reset,
    fetch_sequencer_if.master  bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_HALTED
    } state_t;

    localparam logic [2:0] LAT_LAST = 3'(ROM_LAT - 1);

    state_t            r_state;
    state_t            w_next;
    logic [2:0]        r_lat_cnt;
    logic [DATA_W-1:0] r_ir;
    logic              r_ir_valid;
    logic [ADDR_W-1:0] r_load_addr;
    logic [CNT_W-1:0]  r_retired;

    logic w_lat_done;
    logic w_done;
    logic w_rom_rd;
    logic w_pc_inc;
    logic w_pc_load;
    logic w_halted;
    logic w_busy;

    assign w_lat_done = (r_lat_cnt == LAT_LAST);
    assign w_done     = (r_state == S_EXEC) && bus.exec_done;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (bus.run) w_next = S_FETCH;
            S_FETCH:  if (w_lat_done) w_next = S_DECODE;
            S_DECODE: w_next = S_EXEC;
            S_EXEC: begin
                if (bus.exec_done) begin
                    if (bus.halt)     w_next = S_HALTED;
                    else if (bus.run) w_next = S_FETCH;
                    else              w_next = S_IDLE;
                end
            end
            S_HALTED: w_next = S_HALTED;
            default:  w_next = S_IDLE;
        endcase
    end

    // Output decode; PC strobes are Mealy on the exec_done cycle, halt suppresses both
    always_comb begin
        w_rom_rd  = (r_state == S_FETCH) && (r_lat_cnt == 3'd0);
        w_pc_inc  = w_done && !bus.halt && !bus.branch_req;
        w_pc_load = w_done && !bus.halt && bus.branch_req;
        w_halted  = (r_state == S_HALTED);
        w_busy    = (r_state == S_FETCH) || (r_state == S_DECODE) || (r_state == S_EXEC);
    end

    // Datapath registers: latency counter, IR, ir_valid pulse, load address, retire counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_lat_cnt   <= '0;
            r_ir        <= '0;
            r_ir_valid  <= 1'b0;
            r_load_addr <= '0;
            r_retired   <= '0;
        end else begin
            if (r_state == S_FETCH && !w_lat_done) r_lat_cnt <= r_lat_cnt + 3'd1;
            else                                   r_lat_cnt <= '0;
            if (r_state == S_DECODE) r_ir <= bus.rom_data;
            r_ir_valid <= (r_state == S_DECODE);
            if (w_pc_load) r_load_addr <= bus.branch_target;
            if (w_done && (r_retired != '1)) r_retired <= r_retired + 1'b1;
        end
    end

    // The load address is forwarded during the load cycle so the PC sees it on
    // that edge, and holds the registered copy otherwise.
    assign bus.pc_load_addr = w_pc_load ? bus.branch_target : r_load_addr;
    assign bus.rom_rd       = w_rom_rd;
    assign bus.pc_inc       = w_pc_inc;
    assign bus.pc_load      = w_pc_load;
    assign bus.ir           = r_ir;
    assign bus.ir_valid     = r_ir_valid;
    assign bus.halted       = w_halted;
    assign bus.busy         = w_busy;
    assign bus.retired      = r_retired;
endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: instance A uses ROM_LAT=1 with a 4-bit
// retire counter so saturation is reachable; instance B uses ROM_LAT=3.
module tb_fetch_sequencer;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    fetch_sequencer_if #(.ADDR_W(8), .DATA_W(32), .CNT_W(4))  ifa ();
    fetch_sequencer_if #(.ADDR_W(8), .DATA_W(32), .CNT_W(16)) ifb ();

    fetch_sequencer #(.ADDR_W(8), .DATA_W(32), .ROM_LAT(1), .CNT_W(4))  u_a (
        .clk(clk), .reset(reset), .bus(ifa));
    fetch_sequencer #(.ADDR_W(8), .DATA_W(32), .ROM_LAT(3), .CNT_W(16)) u_b (
        .clk(clk), .reset(reset), .bus(ifb));

    // Advance one cycle; observe 1 time unit after the falling edge
    task automatic next_frame();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        ifa.run = 1'b0; ifa.exec_done = 1'b0; ifa.branch_req = 1'b0;
        ifa.halt = 1'b0; ifa.branch_target = 8'h00; ifa.rom_data = 32'hCAFEF00D;
        ifb.run = 1'b0; ifb.exec_done = 1'b0; ifb.branch_req = 1'b0;
        ifb.halt = 1'b0; ifb.branch_target = 8'h00; ifb.rom_data = 32'h0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        checks++;
        if ({ifa.rom_rd, ifa.pc_inc, ifa.pc_load, ifa.ir_valid, ifa.halted, ifa.busy} !== 6'b0) begin
            failures++;
            $display("FAIL reset_strobes got=%b exp=000000",
                     {ifa.rom_rd, ifa.pc_inc, ifa.pc_load, ifa.ir_valid, ifa.halted, ifa.busy});
        end
        checks++;
        if (ifa.ir !== 32'h0 || ifa.retired !== 4'h0 || ifa.pc_load_addr !== 8'h00) begin
            failures++;
            $display("FAIL reset_regs got ir=%h ret=%h addr=%h exp 0", ifa.ir, ifa.retired, ifa.pc_load_addr);
        end
        checks++;
        if (ifb.busy !== 1'b0 || ifb.ir !== 32'h0) begin
            failures++;
            $display("FAIL reset_b got busy=%b ir=%h exp 0", ifb.busy, ifb.ir);
        end
    endtask

    // exec_done tied high: FETCH, DECODE, EXEC repeating; pc_inc every third cycle
    task automatic test_streaming();
        do_reset();
        ifa.run = 1'b1; ifa.exec_done = 1'b1;
        for (int f = 1; f <= 9; f++) begin
            next_frame();
            checks++;
            if (ifa.pc_inc !== (f % 3 == 0) || ifa.rom_rd !== (f % 3 == 1) || ifa.ir_valid !== (f % 3 == 0)) begin
                failures++;
                $display("FAIL stream_strobes f=%0d got inc=%b rd=%b iv=%b exp inc=%b rd=%b iv=%b", f,
                         ifa.pc_inc, ifa.rom_rd, ifa.ir_valid, (f % 3 == 0), (f % 3 == 1), (f % 3 == 0));
            end
            checks++;
            if (ifa.retired !== 4'((f - 1) / 3) || ifa.busy !== 1'b1 || ifa.pc_load !== 1'b0) begin
                failures++;
                $display("FAIL stream_count f=%0d got ret=%0d busy=%b ld=%b exp ret=%0d busy=1 ld=0", f,
                         ifa.retired, ifa.busy, ifa.pc_load, (f - 1) / 3);
            end
        end
        checks++;
        if (ifa.ir !== 32'hCAFEF00D) begin
            failures++;
            $display("FAIL stream_ir got=%h exp=cafef00d", ifa.ir);
        end
    endtask

    // ROM_LAT=3: three FETCH cycles, single rom_rd, data captured on DECODE exit
    task automatic test_rom_latency();
        do_reset();
        ifb.run = 1'b1;
        for (int f = 1; f <= 5; f++) begin
            next_frame();
            checks++;
            if (ifb.rom_rd !== (f == 1) || ifb.ir_valid !== (f == 5) || ifb.busy !== 1'b1) begin
                failures++;
                $display("FAIL lat3_seq f=%0d got rd=%b iv=%b busy=%b exp rd=%b iv=%b busy=1", f,
                         ifb.rom_rd, ifb.ir_valid, ifb.busy, (f == 1), (f == 5));
            end
            if (f == 4) begin
                checks++;
                if (ifb.ir !== 32'h0) begin
                    failures++;
                    $display("FAIL lat3_early_ir got=%h exp=0", ifb.ir);
                end
                ifb.rom_data = 32'hDEADBEEF;
            end
        end
        checks++;
        if (ifb.ir !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL lat3_ir got=%h exp=deadbeef", ifb.ir);
        end
        ifb.run = 1'b0; ifb.exec_done = 1'b1;
        #1;
        checks++;
        if (ifb.pc_inc !== 1'b1) begin
            failures++;
            $display("FAIL lat3_inc got=%b exp=1", ifb.pc_inc);
        end
        next_frame();
        ifb.exec_done = 1'b0;
        checks++;
        if (ifb.busy !== 1'b0 || ifb.rom_rd !== 1'b0 || ifb.retired !== 16'd1) begin
            failures++;
            $display("FAIL lat3_idle got busy=%b rd=%b ret=%0d exp busy=0 rd=0 ret=1",
                     ifb.busy, ifb.rom_rd, ifb.retired);
        end
    endtask

    task automatic test_branch();
        do_reset();
        ifa.run = 1'b1; ifa.branch_req = 1'b1; ifa.branch_target = 8'h42;
        next_frame(); next_frame(); next_frame();
        checks++;
        if (ifa.pc_load !== 1'b0 || ifa.pc_load_addr !== 8'h00) begin
            failures++;
            $display("FAIL branch_wait got ld=%b addr=%h exp ld=0 addr=00", ifa.pc_load, ifa.pc_load_addr);
        end
        ifa.exec_done = 1'b1;
        #1;
        checks++;
        if (ifa.pc_load !== 1'b1 || ifa.pc_load_addr !== 8'h42 || ifa.pc_inc !== 1'b0) begin
            failures++;
            $display("FAIL branch_load got ld=%b addr=%h inc=%b exp ld=1 addr=42 inc=0",
                     ifa.pc_load, ifa.pc_load_addr, ifa.pc_inc);
        end
        next_frame();
        ifa.exec_done = 1'b0; ifa.branch_target = 8'h11;
        #1;
        checks++;
        if (ifa.pc_load !== 1'b0 || ifa.pc_load_addr !== 8'h42 || ifa.rom_rd !== 1'b1) begin
            failures++;
            $display("FAIL branch_hold got ld=%b addr=%h rd=%b exp ld=0 addr=42 rd=1",
                     ifa.pc_load, ifa.pc_load_addr, ifa.rom_rd);
        end
    endtask

    task automatic test_halt();
        do_reset();
        ifa.run = 1'b1;
        next_frame(); next_frame(); next_frame();
        ifa.halt = 1'b1; ifa.branch_req = 1'b1; ifa.exec_done = 1'b1;
        #1;
        checks++;
        if (ifa.pc_inc !== 1'b0 || ifa.pc_load !== 1'b0) begin
            failures++;
            $display("FAIL halt_strobe got inc=%b ld=%b exp 0 0", ifa.pc_inc, ifa.pc_load);
        end
        for (int f = 0; f < 4; f++) begin
            next_frame();
            ifa.run = f[0];
            ifa.halt = 1'b0; ifa.branch_req = 1'b0;
            checks++;
            if (ifa.halted !== 1'b1 || ifa.busy !== 1'b0 || ifa.rom_rd !== 1'b0 || ifa.retired !== 4'd1) begin
                failures++;
                $display("FAIL halt_stay f=%0d got h=%b busy=%b rd=%b ret=%0d exp h=1 busy=0 rd=0 ret=1", f,
                         ifa.halted, ifa.busy, ifa.rom_rd, ifa.retired);
            end
        end
    endtask

    task automatic test_run_drop();
        do_reset();
        ifa.run = 1'b1;
        next_frame(); next_frame(); next_frame();
        ifa.run = 1'b0;
        for (int f = 0; f < 3; f++) begin
            next_frame();
            checks++;
            if (ifa.busy !== 1'b1 || ifa.pc_inc !== 1'b0) begin
                failures++;
                $display("FAIL drop_wait f=%0d got busy=%b inc=%b exp busy=1 inc=0", f, ifa.busy, ifa.pc_inc);
            end
        end
        next_frame();
        ifa.exec_done = 1'b1;
        #1;
        checks++;
        if (ifa.pc_inc !== 1'b1) begin
            failures++;
            $display("FAIL drop_inc got=%b exp=1", ifa.pc_inc);
        end
        next_frame();
        ifa.exec_done = 1'b0;
        for (int f = 0; f < 2; f++) begin
            checks++;
            if (ifa.busy !== 1'b0 || ifa.pc_inc !== 1'b0 || ifa.rom_rd !== 1'b0 || ifa.halted !== 1'b0) begin
                failures++;
                $display("FAIL drop_idle f=%0d got busy=%b inc=%b rd=%b h=%b exp all 0", f,
                         ifa.busy, ifa.pc_inc, ifa.rom_rd, ifa.halted);
            end
            next_frame();
        end
    endtask

    task automatic test_reset_abort_and_saturate();
        do_reset();
        ifa.run = 1'b1; ifa.exec_done = 1'b1;
        for (int f = 1; f <= 6; f++) next_frame();
        checks++;
        if (ifa.retired !== 4'd1 || ifa.pc_inc !== 1'b1) begin
            failures++;
            $display("FAIL abort_pre got ret=%0d inc=%b exp ret=1 inc=1", ifa.retired, ifa.pc_inc);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (ifa.pc_inc !== 1'b0 || ifa.pc_load !== 1'b0 || ifa.ir !== 32'h0 ||
            ifa.retired !== 4'd0 || ifa.busy !== 1'b0) begin
            failures++;
            $display("FAIL abort got inc=%b ld=%b ir=%h ret=%0d busy=%b exp 0 0 0 0 0",
                     ifa.pc_inc, ifa.pc_load, ifa.ir, ifa.retired, ifa.busy);
        end
        @(negedge clk);
        reset = 1'b0;
        for (int f = 1; f <= 52; f++) begin
            next_frame();
            if (f == 43 || f == 46 || f == 52) begin
                checks++;
                if (ifa.retired !== ((f == 43) ? 4'd14 : 4'd15)) begin
                    failures++;
                    $display("FAIL saturate f=%0d got=%0d exp=%0d", f, ifa.retired, (f == 43) ? 14 : 15);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_rom_latency();
        test_branch();
        test_halt();
        test_run_drop();
        test_reset_abort_and_saturate();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
